barrel_op_pipe32: RTL and testbench
===================================

BARREL_OP_PIPE32 -- requirements
Module: barrel_op_pipe32

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: command present.
REQ-005 SHALL have port in_ready, output, 1: command accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have port op, input, 3: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others illegal.
REQ-007 SHALL have port a, input, 32: operand.
REQ-008 SHALL have port amt, input, 5: shift/rotate amount, 0..31.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: result consumed when out_valid and out_ready are both high at a rising edge.
REQ-011 SHALL have port y, output, 32: result.
REQ-012 SHALL have port err, output, 1: result belongs to an illegal op; qualified by out_valid.
REQ-013 SHALL have port zero, output, 1: y == 0; qualified by out_valid.
REQ-014 SHALL have port op_count, output, CNT_W: number of output handshakes, modulo 2^CNT_W.

Function
REQ-015 SHALL be a two-stage pipeline. Stage 1 is the decode register; stage 2 is the result register driving y, err and zero.
REQ-016 Stage 1 SHALL convert each op to a left-rotate amount and a fill mask. ROL and SLL use amt. ROR, SRL and SRA use (32 - amt) mod 32.
REQ-017 Stage 2 SHALL rotate left using five cascaded conditional rotates by 1, 2, 4, 8 and 16, then apply the mask.
REQ-018 SLL SHALL zero the low amt bits. SRL SHALL zero the high amt bits. SRA SHALL fill the high amt bits with a[31].
REQ-019 With amt == 0, every legal op SHALL produce y = a.
REQ-020 An illegal op SHALL produce y = a and err = 1. It SHALL still occupy the pipeline and increment op_count.
REQ-021 Latency: a command accepted at edge N SHALL appear with out_valid high immediately after edge N+1, when there is no backpressure.
REQ-022 Throughput SHALL be one command per cycle while out_ready is held high.
REQ-023 Stage 2 SHALL advance when it is empty or out_ready is high. Stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-024 in_ready SHALL equal (stage 1 empty) OR (stage 2 empty) OR out_ready, combinationally. No combinational path SHALL exist from in_valid to out_valid.
REQ-025 While out_valid is high and out_ready is low, y, err and zero SHALL hold stable, and no command SHALL be lost or duplicated.
REQ-026 A simultaneous output handshake and input acceptance SHALL shift both stages in the same edge.
REQ-027 op_count SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-028 While reset is high at an edge, both stage valid bits SHALL clear. out_valid, y, err, zero and op_count SHALL become 0, and in_ready SHALL be 1 from the next cycle.
REQ-029 Reset SHALL override any simultaneous handshake. Commands in flight when reset is asserted SHALL be discarded.

Configuration
REQ-030 With macro BARREL_OP_SRA_EN defined, op 100 SHALL perform SRA as specified.
REQ-031 Without BARREL_OP_SRA_EN, op 100 SHALL be treated as illegal (y = a, err = 1), and no sign-fill logic SHALL be synthesized.

Verification
REQ-032 ROL, a=0x80000001, amt=1, out_ready=1 -> y=0x00000003 exactly two cycles after acceptance, err=0.
REQ-033 ROR a=0x00000001 amt=4 -> 0x10000000. SLL a=0xFFFFFFFF amt=8 -> 0xFFFFFF00. SRL a=0x80000000 amt=4 -> 0x08000000. ROR amt=0 -> y=a.
REQ-034 SRA a=0x80000000 amt=4 -> 0xF8000000 with BARREL_OP_SRA_EN. Without the macro -> y=0x80000000, err=1.
REQ-035 Stream 5 commands back-to-back, out_ready low for 3 cycles mid-stream -> in_ready drops after 2 commands are buffered; all 5 results emerge in order with no loss or duplicates; op_count=5.
REQ-036 op=111 a=0x12345678 -> y=0x12345678, err=1. SLL a=0x80000000 amt=1 -> y=0, zero=1.
REQ-037 Assert reset with 2 commands in flight -> out_valid=0 and op_count=0 after the edge; the next command completes normally.

Source files
------------

// File: rtl/barrel_op_pipe32.sv
// barrel_op_pipe32: two-stage shift/rotate pipeline with valid/ready flow control.
// Stage 1 decodes each op into a left-rotate amount plus a keep-mask.
// Stage 2 rotates through a log2 cascade, masks, and registers y/err/zero.
// Optional feature: define BARREL_OP_SRA_EN to enable op 100 (arithmetic
// right shift); without it op 100 is reported as illegal and no sign fill exists.
module barrel_op_pipe32 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [31:0]      a,
  input  logic [4:0]       amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             err,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Stage 1 (decode) registers
  logic        s1_valid_reg;
  logic [31:0] s1_a_reg;
  logic [4:0]  s1_rot_reg;
  logic [31:0] s1_mask_reg;
  logic        s1_err_reg;
`ifdef BARREL_OP_SRA_EN
  logic        s1_fill_reg;
  logic        dec_fill;
`endif

  // Stage 2 (result) registers
  logic             s2_valid_reg;
  logic [31:0]      y_reg;
  logic             err_reg;
  logic             zero_reg;
  logic [CNT_W-1:0] count_reg;

  // Decode outputs and flow control
  logic [4:0]  neg_amt;
  logic [4:0]  dec_rot;
  logic [31:0] dec_mask;
  logic        dec_err;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] y_next;
  logic [31:0] rot_stage [6];

  // A stage moves when it is empty or its downstream consumer takes its content.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = !s1_valid_reg || !s2_valid_reg || out_ready;

  // Right shifts and rotates become left rotates by (32 - amt) mod 32.
  assign neg_amt = ~amt + 5'd1;

  // Translate the opcode into rotate amount, keep-mask and error flag.
  always_comb begin
    dec_rot  = amt;
    dec_mask = ALL_ONES;
    dec_err  = 1'b0;
`ifdef BARREL_OP_SRA_EN
    dec_fill = 1'b0;
`endif
    case (op)
      3'b000: begin
        dec_rot = amt;
      end
      3'b001: begin
        dec_rot = neg_amt;
      end
      3'b010: begin
        dec_mask = ALL_ONES << amt;
      end
      3'b011: begin
        dec_rot  = neg_amt;
        dec_mask = ALL_ONES >> amt;
      end
`ifdef BARREL_OP_SRA_EN
      3'b100: begin
        dec_rot  = neg_amt;
        dec_mask = ALL_ONES >> amt;
        dec_fill = a[31];
      end
`endif
      default: begin
        // Illegal ops pass the operand through untouched and flag an error.
        dec_rot = 5'd0;
        dec_err = 1'b1;
      end
    endcase
  end

  // Stage 1 register: load a new command whenever the stage advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      s1_a_reg     <= a;
      s1_rot_reg   <= dec_rot;
      s1_mask_reg  <= dec_mask;
      s1_err_reg   <= dec_err;
`ifdef BARREL_OP_SRA_EN
      s1_fill_reg  <= dec_fill;
`endif
    end
  end

  // Rotate-left cascade: bit gi of the amount enables a rotate by 2**gi.
  assign rot_stage[0] = s1_a_reg;
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_rot
      localparam int SH = 1 << gi;
      assign rot_stage[gi+1] = s1_rot_reg[gi]
          ? ((rot_stage[gi] << SH) | (rot_stage[gi] >> (32 - SH)))
          : rot_stage[gi];
    end
  endgenerate

  // Masked-off bits are cleared, or sign-filled for arithmetic right shifts.
`ifdef BARREL_OP_SRA_EN
  assign y_next = (rot_stage[5] & s1_mask_reg) | ({32{s1_fill_reg}} & ~s1_mask_reg);
`else
  assign y_next = rot_stage[5] & s1_mask_reg;
`endif

  // Stage 2 register: capture the result; hold it while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      y_reg        <= 32'd0;
      err_reg      <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      y_reg        <= y_next;
      err_reg      <= s1_err_reg;
      zero_reg     <= (y_next == 32'd0);
    end
  end

  // Count output handshakes; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (s2_valid_reg && out_ready) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign out_valid = s2_valid_reg;
  assign y         = y_reg;
  assign err       = err_reg;
  assign zero      = zero_reg;
  assign op_count  = count_reg;

endmodule

// File: tb/tb_barrel_op_pipe32.sv
// Testbench for barrel_op_pipe32: directed vector table plus hand-written
// sequences for backpressure, counter wrap and reset with work in flight.
// Expectations for op 100 follow whether BARREL_OP_SRA_EN is defined.
module tb_barrel_op_pipe32;

  localparam int CW = 4;
  localparam int NV = 17;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [31:0]   a;
  logic [4:0]    amt;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   y;
  logic          err;
  logic          zero;
  logic [CW-1:0] op_count;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [4:0]  amt;
    logic [31:0] y;
    logic        err;
    logic        zero;
  } vec_t;

  vec_t          vecs [NV];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_cnt = '0;

  barrel_op_pipe32 #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .amt(amt), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .err(err), .zero(zero), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One command through an otherwise empty pipe with out_ready held high.
  task automatic run_vec(input int idx);
    op = vecs[idx].op; a = vecs[idx].a; amt = vecs[idx].amt;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("v%0d latency out_valid", idx), {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
    check($sformatf("v%0d y", idx), y, vecs[idx].y);
    check($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, vecs[idx].err});
    check($sformatf("v%0d zero", idx), {31'd0, zero}, {31'd0, vecs[idx].zero});
    exp_cnt = exp_cnt + 1'b1;
    @(posedge clk); #1;
    check($sformatf("v%0d drained", idx), {31'd0, out_valid}, 32'd0);
    check($sformatf("v%0d op_count", idx), {28'd0, op_count}, {28'd0, exp_cnt});
    $display("vec %0d op=%b a=%08h amt=%0d -> y=%08h err=%b zero=%b count=%0d",
             idx, vecs[idx].op, vecs[idx].a, vecs[idx].amt, y, err, zero, op_count);
  endtask

  initial begin
    logic [31:0] exp_y [5];
    int sent, recv, cyc;
    logic in_fire, out_fire;

    vecs[0]  = '{3'b000, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'h0000_0001, 5'd4,  32'h1000_0000, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FF00, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
`ifdef BARREL_OP_SRA_EN
    vecs[5]  = '{3'b100, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0};
    vecs[13] = '{3'b100, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 1'b0, 1'b0};
`else
    vecs[5]  = '{3'b100, 32'h8000_0000, 5'd4,  32'h8000_0000, 1'b1, 1'b0};
    vecs[13] = '{3'b100, 32'h7FFF_FFF0, 5'd4,  32'h7FFF_FFF0, 1'b1, 1'b0};
`endif
    vecs[6]  = '{3'b111, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b1, 1'b0};
    vecs[7]  = '{3'b010, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 32'h1234_5678, 5'd4,  32'h2345_6781, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 1'b0};
    vecs[10] = '{3'b011, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0, 1'b0};
    vecs[11] = '{3'b010, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
    vecs[12] = '{3'b101, 32'h0000_0000, 5'd3,  32'h0000_0000, 1'b1, 1'b1};
    vecs[14] = '{3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
    vecs[15] = '{3'b010, 32'h0000_1234, 5'd0,  32'h0000_1234, 1'b0, 1'b0};
    vecs[16] = '{3'b011, 32'h0000_000F, 5'd4,  32'h0000_0000, 1'b0, 1'b1};

    // Reset state
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    op = 3'b000; a = 32'hFFFF_FFFF; amt = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset y", y, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd0);
    check("reset op_count", {28'd0, op_count}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < NV; i++) run_vec(i);

    // Streaming with a three-cycle output stall after two commands
    for (int i = 0; i < 5; i++) exp_y[i] = (32'h100 + 32'(i)) << 1;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 5 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 5);
      op = 3'b000; amt = 5'd1; a = 32'h100 + 32'(sent);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        check($sformatf("stall c%0d in_ready", cyc), {31'd0, in_ready}, 32'd0);
        check($sformatf("stall c%0d y held", cyc), y, exp_y[0]);
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        check($sformatf("stream y%0d", recv), y, exp_y[recv]);
        check($sformatf("stream err%0d", recv), {31'd0, err}, 32'd0);
        $display("stream out %0d y=%08h cycle=%0d", recv, y, cyc);
        recv++;
        exp_cnt = exp_cnt + 1'b1;
      end
      if (in_fire) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream received", 32'(recv), 32'd5);
    check("stream op_count wrapped", {28'd0, op_count}, {28'd0, exp_cnt});
    @(posedge clk); #1;
    check("stream no duplicate", {31'd0, out_valid}, 32'd0);

    // Reset with two commands in flight, competing with a handshake
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b000; amt = 5'd0; a = 32'hAAAA_0001;
    @(posedge clk); #1;
    a = 32'hAAAA_0002;
    @(posedge clk); #1;
    check("inflight out_valid", {31'd0, out_valid}, 32'd1);
    a = 32'hAAAA_0003; out_ready = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush op_count", {28'd0, op_count}, 32'd0);
    check("flush y", y, 32'd0);
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    exp_cnt = '0;
    @(posedge clk); #1;
    check("flush no ghost", {31'd0, out_valid}, 32'd0);
    $display("reset flush: out_valid=%b op_count=%0d", out_valid, op_count);
    run_vec(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
